// File: rtl/hdmi_packet_scheduler_if.sv
// rtl/hdmi_packet_scheduler_if.sv - stereo audio sample stream into the packet scheduler
interface hdmi_packet_scheduler_if #(
    parameter int AUDIO_BIT_WIDTH = 16
);
    logic                         sample_valid;
    logic                         sample_ready;
    logic [2*AUDIO_BIT_WIDTH-1:0] sample_data;

    modport master (output sample_valid, output sample_data, input sample_ready);
    modport slave  (input sample_valid, input sample_data, output sample_ready);
endinterface

// File: rtl/hdmi_packet_scheduler.sv
// rtl/hdmi_packet_scheduler.sv - per-slot HDMI data-island packet arbitration (ACR, audio, InfoFrames)
module hdmi_packet_scheduler #(
    parameter int AUDIO_BIT_WIDTH = 16,
    parameter int FIFO_DEPTH      = 8,
    parameter int NUM_INFOFRAMES  = 4,
    parameter int FLUSH_SLOTS     = 4
) (
    input  logic                      clk_pixel,
    input  logic                      reset_n,
    input  logic                      video_field_end,
    input  logic                      packet_enable,
    input  logic [4:0]                packet_pixel_counter,
    input  logic                      acr_request,
    hdmi_packet_scheduler_if.slave    smp,
    input  logic [NUM_INFOFRAMES-1:0] infoframe_enable,
    output logic [7:0]                packet_type,
    output logic [191:0]              audio_words,
    output logic [3:0]                audio_present,
    output logic [7:0]                frame_counter,
    output logic                      acr_overrun
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = 2 * AUDIO_BIT_WIDTH;

    logic [SW-1:0]             fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]             count_q, count_d;
    logic [3:0]                flush_age_q, flush_age_d;
    logic                      acr_pending_q, acr_pending_d;
    logic                      acr_overrun_q, acr_overrun_d;
    logic [NUM_INFOFRAMES-1:0] sent_q, sent_d;
    logic [7:0]                packet_type_q, packet_type_d;
    logic [191:0]              audio_words_q, audio_words_d;
    logic [3:0]                audio_present_q, audio_present_d;
    logic [7:0]                frame_counter_q, frame_counter_d;

    logic                      full, push;
    logic [2:0]                pop_n;
    logic                      if_found;
    logic [2:0]                if_idx;
    logic [NUM_INFOFRAMES-1:0] if_sel;
    logic [SW-1:0]             rd_word;
    logic [8:0]                fc_sum;

    function automatic logic [23:0] justify(input logic [AUDIO_BIT_WIDTH-1:0] s);
        return 24'(s) << (24 - AUDIO_BIT_WIDTH);
    endfunction

    assign full             = (count_q == CW'(FIFO_DEPTH));
    assign push             = smp.sample_valid && !full;
    assign smp.sample_ready = !full;

    // Descending scan so the lowest eligible slot index wins.
    always_comb begin
        if_found = 1'b0;
        if_idx   = '0;
        if_sel   = '0;
        for (int i = NUM_INFOFRAMES - 1; i >= 0; i--) begin
            if (infoframe_enable[i] && !sent_q[i]) begin
                if_found  = 1'b1;
                if_idx    = 3'(i);
                if_sel    = '0;
                if_sel[i] = 1'b1;
            end
        end
    end

    always_comb begin
        packet_type_d   = packet_type_q;
        audio_words_d   = audio_words_q;
        audio_present_d = audio_present_q;
        sent_d          = sent_q;
        acr_pending_d   = acr_pending_q;
        acr_overrun_d   = acr_overrun_q;
        flush_age_d     = flush_age_q;
        frame_counter_d = frame_counter_q;
        pop_n           = 3'd0;
        rd_word         = '0;
        fc_sum          = '0;

        if (video_field_end) begin
            sent_d        = '0;
            packet_type_d = 8'h00;
        end else if (packet_enable) begin
            if (acr_pending_q) begin
                packet_type_d = 8'h01;
                acr_pending_d = 1'b0;
            end else if (count_q >= CW'(4)) begin
                pop_n = 3'd4;
            end else if (count_q != '0 && flush_age_q >= 4'(FLUSH_SLOTS)) begin
                pop_n = 3'(count_q);
            end else if (if_found) begin
                packet_type_d = 8'h81 + 8'(if_idx);
                sent_d        = sent_q | if_sel;
            end else begin
                packet_type_d = 8'h00;
            end
        end

        if (pop_n != 3'd0) begin
            packet_type_d   = 8'h02;
            audio_present_d = 4'b1111 >> (3'd4 - pop_n);
            audio_words_d   = '0;
            for (int k = 0; k < 4; k++) begin
                if (3'(k) < pop_n) begin
                    rd_word = fifo_mem[rd_ptr_q + PW'(k)];
                    audio_words_d[(2*k)*24 +: 24]   = justify(rd_word[AUDIO_BIT_WIDTH-1:0]);
                    audio_words_d[(2*k+1)*24 +: 24] = justify(rd_word[SW-1:AUDIO_BIT_WIDTH]);
                end
            end
        end

        if (count_q == '0 || pop_n != 3'd0) begin
            flush_age_d = 4'd0;
        end else if (packet_enable && !video_field_end && count_q < CW'(4) && flush_age_q != 4'd15) begin
            flush_age_d = flush_age_q + 4'd1;
        end

        // A new request on the grant cycle re-arms pending after the grant clears it.
        if (acr_request) begin
            if (acr_pending_q) acr_overrun_d = 1'b1;
            acr_pending_d = 1'b1;
        end

        if (packet_pixel_counter == 5'd31 && packet_type_q == 8'h02) begin
            fc_sum          = {1'b0, frame_counter_q} + 9'($countones(audio_present_q));
            frame_counter_d = (fc_sum >= 9'd192) ? 8'(fc_sum - 9'd192) : fc_sum[7:0];
        end
    end

    assign wr_ptr_d = wr_ptr_q + PW'(push);
    assign rd_ptr_d = rd_ptr_q + PW'(pop_n);
    assign count_d  = count_q + CW'(push) - CW'(pop_n);

    always_ff @(posedge clk_pixel) begin
        if (push) fifo_mem[wr_ptr_q] <= smp.sample_data;
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            flush_age_q     <= '0;
            acr_pending_q   <= 1'b0;
            acr_overrun_q   <= 1'b0;
            sent_q          <= '0;
            packet_type_q   <= 8'h00;
            audio_words_q   <= '0;
            audio_present_q <= '0;
            frame_counter_q <= '0;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            flush_age_q     <= flush_age_d;
            acr_pending_q   <= acr_pending_d;
            acr_overrun_q   <= acr_overrun_d;
            sent_q          <= sent_d;
            packet_type_q   <= packet_type_d;
            audio_words_q   <= audio_words_d;
            audio_present_q <= audio_present_d;
            frame_counter_q <= frame_counter_d;
        end
    end

    assign packet_type   = packet_type_q;
    assign audio_words   = audio_words_q;
    assign audio_present = audio_present_q;
    assign frame_counter = frame_counter_q;
    assign acr_overrun   = acr_overrun_q;
endmodule

// File: tb/tb_hdmi_packet_scheduler.sv
// tb/tb_hdmi_packet_scheduler.sv - scoreboard bench for hdmi_packet_scheduler
module tb_hdmi_packet_scheduler;
    localparam int AW    = 20;
    localparam int SW    = 2 * AW;
    localparam int DEPTH = 8;
    localparam int NIF   = 4;
    localparam int FLUSH = 4;

    logic           clk_pixel = 1'b0;
    logic           reset_n;
    logic           video_field_end, packet_enable, acr_request;
    logic [4:0]     packet_pixel_counter;
    logic [NIF-1:0] infoframe_enable;
    logic [7:0]     packet_type, frame_counter;
    logic [191:0]   audio_words;
    logic [3:0]     audio_present;
    logic           acr_overrun;

    hdmi_packet_scheduler_if #(.AUDIO_BIT_WIDTH(AW)) smp ();

    hdmi_packet_scheduler #(
        .AUDIO_BIT_WIDTH(AW), .FIFO_DEPTH(DEPTH), .NUM_INFOFRAMES(NIF), .FLUSH_SLOTS(FLUSH)
    ) dut (
        .clk_pixel(clk_pixel), .reset_n(reset_n), .video_field_end(video_field_end),
        .packet_enable(packet_enable), .packet_pixel_counter(packet_pixel_counter),
        .acr_request(acr_request), .smp(smp), .infoframe_enable(infoframe_enable),
        .packet_type(packet_type), .audio_words(audio_words), .audio_present(audio_present),
        .frame_counter(frame_counter), .acr_overrun(acr_overrun)
    );

    always #5 clk_pixel = ~clk_pixel;

    typedef struct {
        logic [7:0]   ty;
        logic [3:0]   pr;
        logic [191:0] w;
        logic [7:0]   fc;
        logic         ov;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    logic slot_prev = 1'b0;

    // Reference model state: sample queue plus the arbitration bookkeeping.
    logic [SW-1:0] mq[$];
    bit            m_pend, m_ovr;
    int            m_age, m_fc;
    bit [NIF-1:0]  m_sent;
    logic [7:0]    m_type;
    logic [3:0]    m_pres;
    logic [191:0]  m_words;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    function automatic logic [23:0] just(input logic [AW-1:0] s);
        return {s, {(24 - AW){1'b0}}};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_pend = 0; m_ovr = 0; m_age = 0; m_fc = 0; m_sent = '0;
        m_type = 8'h00; m_pres = 4'h0; m_words = '0;
    endtask

    task automatic model_step(input bit ve, input bit pe, input logic [4:0] pix,
                              input bit acr, input bit sv, input logic [SW-1:0] d);
        int sz, n;
        bit old_pend;
        logic [SW-1:0] s;
        sz = mq.size();
        old_pend = m_pend;
        n = 0;
        if (pix == 5'd31 && m_type == 8'h02) m_fc = (m_fc + $countones(m_pres)) % 192;
        if (ve) begin
            m_sent = '0;
            m_type = 8'h00;
        end else if (pe) begin
            if (m_pend) begin
                m_type = 8'h01;
                m_pend = 0;
            end else if (sz >= 4) n = 4;
            else if (sz >= 1 && m_age >= FLUSH) n = sz;
            else begin
                m_type = 8'h00;
                for (int i = 0; i < NIF; i++) begin
                    if (infoframe_enable[i] && !m_sent[i]) begin
                        m_type = 8'(8'h81 + i);
                        m_sent[i] = 1'b1;
                        break;
                    end
                end
            end
            if (n > 0) begin
                m_type = 8'h02; m_pres = '0; m_words = '0;
                for (int k = 0; k < n; k++) begin
                    s = mq.pop_front();
                    m_pres[k] = 1'b1;
                    m_words[(2*k)*24 +: 24]   = just(s[AW-1:0]);
                    m_words[(2*k+1)*24 +: 24] = just(s[SW-1:AW]);
                end
            end
        end
        if (sz == 0 || n > 0) m_age = 0;
        else if (pe && !ve && sz < 4 && m_age < 15) m_age++;
        if (acr) begin
            if (old_pend) m_ovr = 1;
            m_pend = 1;
        end
        if (sv && sz < DEPTH) mq.push_back(d);
    endtask

    function automatic logic [SW-1:0] rand_sample();
        return SW'({$urandom(), $urandom()});
    endfunction

    task automatic cycle(input bit ve, input bit pe, input logic [4:0] pix,
                         input bit acr, input bit sv, input logic [SW-1:0] d);
        chk("sample_ready", 192'(smp.sample_ready), 192'(mq.size() < DEPTH));
        video_field_end = ve; packet_enable = pe; packet_pixel_counter = pix;
        acr_request = acr; smp.sample_valid = sv; smp.sample_data = d;
        model_step(ve, pe, pix, acr, sv, d);
        if (pe || ve) exp_q.push_back('{m_type, m_pres, m_words, 8'(m_fc), m_ovr});
        @(negedge clk_pixel); #1;
        video_field_end = 0; packet_enable = 0; acr_request = 0; smp.sample_valid = 0;
    endtask

    task automatic push_samples(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 5'd0, 0, 1, rand_sample());
    endtask

    task automatic run_slot(input bit pe, input bit ve, input int sv_mod, input int acr_mod, input int len);
        for (int p = 0; p < len; p++) begin
            bit sv, ac;
            sv = (sv_mod != 0) && ($urandom_range(0, sv_mod - 1) == 0);
            ac = (acr_mod != 0) && ($urandom_range(0, acr_mod - 1) == 0);
            cycle(ve && p == 0, pe && p == 0, 5'(p), ac, sv, rand_sample());
        end
    endtask

    always @(posedge clk_pixel) slot_prev <= packet_enable | video_field_end;

    always @(negedge clk_pixel) begin
        if (slot_prev && reset_n) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL scoreboard: slot output with no expected entry");
            end else begin
                mon_e = exp_q.pop_front();
                chk("packet_type", 192'(packet_type), 192'(mon_e.ty));
                chk("audio_present", 192'(audio_present), 192'(mon_e.pr));
                chk("audio_words", audio_words, mon_e.w);
                chk("frame_counter", 192'(frame_counter), 192'(mon_e.fc));
                chk("acr_overrun", 192'(acr_overrun), 192'(mon_e.ov));
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_type"}, 192'(packet_type), 192'(8'h00));
        chk({tag, "_present"}, 192'(audio_present), 192'(4'h0));
        chk({tag, "_words"}, audio_words, 192'(0));
        chk({tag, "_fc"}, 192'(frame_counter), 192'(8'd0));
        chk({tag, "_ovr"}, 192'(acr_overrun), 192'(1'b0));
        chk({tag, "_ready"}, 192'(smp.sample_ready), 192'(1'b1));
    endtask

    initial begin
        reset_n = 0; video_field_end = 0; packet_enable = 0; acr_request = 0;
        packet_pixel_counter = '0; infoframe_enable = '0;
        smp.sample_valid = 0; smp.sample_data = '0;
        model_reset();
        repeat (3) @(negedge clk_pixel);
        check_reset_outputs("reset");
        #1 reset_n = 1;

        // ACR outranks a full audio group, audio follows on the next slot
        push_samples(4);
        cycle(0, 0, 5'd0, 1, 0, '0);
        run_slot(1, 0, 0, 0, 32);
        chk("acr_first", 192'(packet_type), 192'(8'h01));
        run_slot(1, 0, 0, 0, 32);
        chk("audio_after_acr", 192'(packet_type), 192'(8'h02));
        chk("audio_after_acr_pr", 192'(audio_present), 192'(4'b1111));
        run_slot(1, 0, 0, 0, 32);
        chk("fifo_drained", 192'(packet_type), 192'(8'h00));

        // Partial group waits FLUSH_SLOTS slots then is forced out
        push_samples(2);
        for (int s = 0; s < 4; s++) begin
            run_slot(1, 0, 0, 0, 32);
            chk("flush_wait", 192'(packet_type), 192'(8'h00));
        end
        run_slot(1, 0, 0, 0, 32);
        chk("flush_type", 192'(packet_type), 192'(8'h02));
        chk("flush_present", 192'(audio_present), 192'(4'b0011));
        chk("flush_zero_words", 192'(audio_words[191:96]), 192'(0));

        // InfoFrame rotation, restarted by field end
        infoframe_enable = 4'b1011;
        for (int r = 0; r < 2; r++) begin
            run_slot(1, 0, 0, 0, 32); chk("if_81", 192'(packet_type), 192'(8'h81));
            run_slot(1, 0, 0, 0, 32); chk("if_82", 192'(packet_type), 192'(8'h82));
            run_slot(1, 0, 0, 0, 32); chk("if_84", 192'(packet_type), 192'(8'h84));
            run_slot(1, 0, 0, 0, 32); chk("if_null", 192'(packet_type), 192'(8'h00));
            cycle(1, 0, 5'd0, 0, 0, '0);
        end
        infoframe_enable = '0;

        // Backpressure at full and recovery after one grant
        push_samples(8);
        chk("full_ready", 192'(smp.sample_ready), 192'(1'b0));
        push_samples(2);
        cycle(0, 1, 5'd0, 0, 1, rand_sample());
        chk("ready_restored", 192'(smp.sample_ready), 192'(1'b1));
        run_slot(1, 0, 0, 0, 32);

        for (int s = 0; s < 150; s++) begin
            bit ve, pe;
            if ($urandom_range(0, 7) == 0) infoframe_enable = 4'($urandom());
            ve = ($urandom_range(0, 15) == 0);
            pe = ($urandom_range(0, 15) != 0);
            run_slot(pe, ve, 10, 40, 32);
        end
        infoframe_enable = '0;

        // Reset mid-slot drops the FIFO and the granted packet
        push_samples(6);
        run_slot(1, 0, 0, 0, 10);
        #1 reset_n = 0;
        #1 check_reset_outputs("midslot_reset");
        model_reset();
        @(negedge clk_pixel); #1 reset_n = 1;
        run_slot(1, 0, 0, 0, 32);
        chk("post_reset_null", 192'(packet_type), 192'(8'h00));

        // Frame counter wrap modulo 192, then ACR overrun
        for (int s = 0; s < 47; s++) begin
            push_samples(4);
            run_slot(1, 0, 0, 0, 32);
        end
        chk("fc_188", 192'(frame_counter), 192'(8'd188));
        push_samples(4);
        run_slot(1, 0, 0, 0, 32);
        chk("fc_wrap", 192'(frame_counter), 192'(8'd0));
        cycle(0, 0, 5'd0, 1, 0, '0);
        cycle(0, 0, 5'd0, 1, 0, '0);
        chk("acr_overrun", 192'(acr_overrun), 192'(1'b1));

        // Field end beats a simultaneous slot; ACR stays pending
        cycle(1, 1, 5'd0, 0, 0, '0);
        chk("fe_wins", 192'(packet_type), 192'(8'h00));
        run_slot(1, 0, 0, 0, 32);
        chk("acr_after_fe", 192'(packet_type), 192'(8'h01));

        @(negedge clk_pixel);
        chk("scoreboard_drained", 192'(exp_q.size()), 192'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hdmi_packet_scheduler.md
HDMI_PACKET_SCHEDULER -- requirements
Module: hdmi_packet_scheduler

Interface
REQ-001 SHALL have parameter AUDIO_BIT_WIDTH, default 16, meaning bits per audio sample per channel (16..24).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning stereo-sample FIFO entries (power of 2, 4..32).
REQ-003 SHALL have parameter NUM_INFOFRAMES, default 4, meaning InfoFrame slots (1..8); slot i maps to packet type 8'h81+i.
REQ-004 SHALL have parameter FLUSH_SLOTS, default 4, meaning packet slots a partial audio group may wait before forced send (1..15).
REQ-005 SHALL have the following ports, one per line (name, direction, width, meaning):
  clk_pixel  in  1  pixel clock, sole clock.
  reset_n  in  1  reset, asynchronous, active-low.
  video_field_end  in  1  single-cycle end-of-field pulse.
  packet_enable  in  1  single-cycle pulse at start of each packet slot.
  packet_pixel_counter  in  5  pixel index within the current packet slot.
  acr_request  in  1  pulse requesting an Audio Clock Regeneration packet.
  sample_valid  in  1  stereo sample offered.
  sample_ready  out  1  FIFO can accept a sample.
  sample_data  in  2*AUDIO_BIT_WIDTH  {right, left} sample.
  infoframe_enable  in  NUM_INFOFRAMES  per-slot InfoFrame enable.
  packet_type  out  8  selected packet type for the current slot.
  audio_words  out  4*2*24  samples for type 8'h02, sample k channel c at [(2k+c)*24 +: 24], left-justified, zero-padded.
  audio_present  out  4  sample-present bits for type 8'h02.
  frame_counter  out  8  IEC 60958 frame index of first sample in packet.
  acr_overrun  out  1  sticky: acr_request while one already pending.

Function
REQ-006 SHALL write sample_data into FIFO when sample_valid && sample_ready; sample_ready SHALL equal !full.
REQ-007 SHALL keep fill count 0..FIFO_DEPTH; same-cycle push and pop SHALL update count by push minus number popped.
REQ-008 SHALL evaluate arbitration only on cycles with packet_enable=1 and video_field_end=0; outputs update on the next clock edge and hold until the next arbitration or field end.
REQ-009 Priority 1: ACR pending -> packet_type 8'h01, pending cleared.
REQ-010 Priority 2: count >= 4 -> packet_type 8'h02, pop 4 oldest samples, audio_present 4'b1111.
REQ-011 Priority 3: 1 <= count <= 3 and flush_age >= FLUSH_SLOTS -> packet_type 8'h02, pop all count samples, audio_present low bits set (count 2 -> 4'b0011), absent words zero.
REQ-012 Priority 4: lowest index i with infoframe_enable[i]=1 and not sent this field -> packet_type 8'h81+i, mark i sent.
REQ-013 Otherwise packet_type SHALL be 8'h00 (null); audio_words/audio_present SHALL hold last values for non-audio types.
REQ-014 acr_request sets pending; acr_request arriving while pending SHALL set acr_overrun; acr_request on the same cycle an ACR grant clears pending SHALL leave pending set.
REQ-015 flush_age SHALL increment (saturating at 15) at each arbitration where 1 <= count <= 3 and no audio packet granted; SHALL clear on any audio grant or when count = 0.
REQ-016 frame_counter SHALL advance, when packet_pixel_counter = 31 and packet_type = 8'h02, by the number of present samples, modulo 192 (e.g. 190 + 4 -> 2).
REQ-017 video_field_end SHALL clear all InfoFrame sent flags and force packet_type to 8'h00; it SHALL win over a simultaneous packet_enable (no grant, no pop, ACR stays pending).
REQ-018 Deasserting infoframe_enable[i] SHALL only skip slot i; its sent flag is unaffected.

Reset
REQ-019 On reset_n=0, asynchronously: FIFO empty, sample_ready=1, packet_type=8'h00, audio_words=0, audio_present=0, frame_counter=0, flush_age=0, ACR pending=0, acr_overrun=0, all sent flags=0.
REQ-020 Reset mid-slot SHALL discard FIFO contents and any granted packet; first arbitration after release follows REQ-009..013 normally.

Verification
REQ-021 Push 4 samples, ACR pulse, then packet_enable -> type 8'h01; next packet_enable -> type 8'h02, present 4'b1111, count 0.
REQ-022 Push 2 samples, FLUSH_SLOTS=4, infoframes disabled -> four null slots, fifth slot type 8'h02, present 4'b0011, words 2..3 zero.
REQ-023 infoframe_enable=4'b1011, FIFO empty -> slots yield 8'h81, 8'h82, 8'h84, 8'h00; after video_field_end, sequence repeats.
REQ-024 Hold sample_valid=1 with no slots, FIFO_DEPTH=8 -> sample_ready drops after 8th accept; one audio grant restores ready next cycle.
REQ-025 frame_counter=188, grant 4-sample packet, counter 31 -> frame_counter=0; two ACR pulses without grant -> acr_overrun=1.
REQ-026 video_field_end and packet_enable together with ACR pending -> packet_type 8'h00, ACR granted at next packet_enable.
